// File: rtl/stream_rr_arbiter_if.sv
// rtl/stream_rr_arbiter_if.sv - valid/ready bundle joining N_INP upstream streams, the arbiter and its downstream sink
interface stream_rr_arbiter_if #(
   parameter type DATA_T = logic [31:0],
   parameter int  N_INP  = 2
);

   // Upstream side: one payload/valid/ready triple per input stream.
   DATA_T [N_INP-1:0] inp_data_i;
   logic  [N_INP-1:0] inp_valid_i;
   logic  [N_INP-1:0] inp_ready_o;

   // Downstream side: the single merged stream.
   DATA_T             oup_data_o;
   logic              oup_valid_o;
   logic              oup_ready_i;

   // Arbiter view: consumes upstream valid/data and downstream ready.
   modport slave (
      input  inp_data_i,
      input  inp_valid_i,
      input  oup_ready_i,
      output inp_ready_o,
      output oup_data_o,
      output oup_valid_o
   );

   // Environment view: drives the streams into the arbiter.
   modport master (
      output inp_data_i,
      output inp_valid_i,
      output oup_ready_i,
      input  inp_ready_o,
      input  oup_data_o,
      input  oup_valid_o
   );

endinterface

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - zero-latency round-robin merge of N_INP valid/ready streams; STREAM_ARBITER_ASSERT_EN enables protocol checks
module stream_rr_arbiter #(
   parameter type DATA_T = logic [31:0],
   parameter int  N_INP  = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   stream_rr_arbiter_if.slave bus
);

   localparam int PTR_W = (N_INP > 1) ? $clog2(N_INP) : 1;

   typedef logic [PTR_W-1:0] idx_t;

   // Registered state: rotation pointer plus the stall lock.
   idx_t ptr_q;
   idx_t ptr_d;
   logic lock_q;
   logic lock_d;
   idx_t lock_idx_q;
   idx_t lock_idx_d;

   // Combinational arbitration results.
   logic any_valid;
   logic locked_valid;
   logic lock_hold;
   logic hi_found;
   idx_t hi_idx;
   logic lo_found;
   idx_t lo_idx;
   idx_t grant;
   logic handshake;
   logic stall;

   // Valid of the locked input; the loop keeps every index a constant.
   always_comb begin
      locked_valid = 1'b0;
      for (int i = 0; i < N_INP; i++) begin
         if (idx_t'(i) == lock_idx_q) begin
            locked_valid = bus.inp_valid_i[i];
         end
      end
   end

   // Round-robin search: lowest valid index at or above ptr, else lowest valid overall (wrap).
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = ptr_q;
      lo_found = 1'b0;
      lo_idx   = ptr_q;
      for (int i = N_INP - 1; i >= 0; i--) begin
         if (bus.inp_valid_i[i]) begin
            lo_found = 1'b1;
            lo_idx   = idx_t'(i);
            if (idx_t'(i) >= ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = idx_t'(i);
            end
         end
      end
   end

   // Grant: a held lock wins while its input stays valid, otherwise the round-robin pick.
   always_comb begin
      any_valid = |bus.inp_valid_i;
      lock_hold = lock_q & locked_valid;
      grant     = ptr_q;
      if (lock_hold) begin
         grant = lock_idx_q;
      end else if (hi_found) begin
         grant = hi_idx;
      end else if (lo_found) begin
         grant = lo_idx;
      end
      handshake = any_valid & bus.oup_ready_i;
      stall     = any_valid & ~bus.oup_ready_i;
   end

   // Output payload/valid; depends only on valids, data and state, never on oup_ready_i.
   always_comb begin
      bus.oup_valid_o = any_valid;
      bus.oup_data_o  = '0;
      for (int i = 0; i < N_INP; i++) begin
         if (any_valid && (idx_t'(i) == grant)) begin
            bus.oup_data_o = bus.inp_data_i[i];
         end
      end
   end

   // Per-input ready: only the granted input sees the downstream ready.
   always_comb begin
      bus.inp_ready_o = '0;
      for (int i = 0; i < N_INP; i++) begin
         bus.inp_ready_o[i] = handshake & (idx_t'(i) == grant);
      end
   end

   // Next state: rotate past the winner on handshake, lock the winner while stalled.
   always_comb begin
      ptr_d      = ptr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (handshake) begin
         ptr_d  = (grant == idx_t'(N_INP - 1)) ? '0 : grant + idx_t'(1);
         lock_d = 1'b0;
      end else if (stall) begin
         lock_d     = 1'b1;
         lock_idx_d = grant;
      end else begin
         // Nothing requesting: a lock whose input vanished is stale.
         lock_d = 1'b0;
      end
   end

   // State register; reset discards any pending lock.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

`ifdef STREAM_ARBITER_ASSERT_EN
   if (N_INP < 1) begin : g_bad_n_inp
      $fatal(1, "stream_rr_arbiter: N_INP must be at least 1");
   end

   for (genvar gi = 0; gi < N_INP; gi++) begin : g_inp_chk
      // A pending upstream request must be held with a stable payload.
      assert property (@(posedge clk_i) disable iff (!rst_ni)
         (bus.inp_valid_i[gi] && !bus.inp_ready_o[gi])
            |=> (bus.inp_valid_i[gi] && $stable(bus.inp_data_i[gi])))
      else $error("stream_rr_arbiter: input %0d dropped valid or changed data while waiting", gi);
   end

   // A stalled output must present the same payload next cycle.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (bus.oup_valid_o && !bus.oup_ready_i) |=> $stable(bus.oup_data_o))
   else $error("stream_rr_arbiter: output payload changed while stalled");

   // At most one input is accepted per cycle.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(bus.inp_ready_o))
   else $error("stream_rr_arbiter: more than one inp_ready_o asserted");
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - randomized and directed checks of stream_rr_arbiter against a priority-queue model
module tb_stream_rr_arbiter;

   localparam int N = 4;
   typedef logic [31:0] data_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   stream_rr_arbiter_if #(.DATA_T(data_t), .N_INP(N)) bus ();
   stream_rr_arbiter_if #(.DATA_T(data_t), .N_INP(1)) bus1 ();

   stream_rr_arbiter #(.DATA_T(data_t), .N_INP(N)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   stream_rr_arbiter #(.DATA_T(data_t), .N_INP(1)) dut1 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus1)
   );

   int    checks = 0;
   int    errors = 0;
   data_t d [N];

   // Reference model: priority order as a queue (head = highest priority) plus the held index.
   int order[$];
   int held;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      order.delete();
      for (int i = 0; i < N; i++) order.push_back(i);
      held = -1;
   endtask

   function automatic int exp_grant(input logic [N-1:0] v);
      if (held >= 0 && v[held]) return held;
      foreach (order[k]) begin
         if (v[order[k]]) return order[k];
      end
      return -1;
   endfunction

   task automatic model_advance(input logic [N-1:0] v, input logic rdy);
      int g;
      g = exp_grant(v);
      if (g < 0) begin
         held = -1;
      end else if (rdy) begin
         // Winner moves to the back of the priority order.
         while (order[0] != g) order.push_back(order.pop_front());
         order.push_back(order.pop_front());
         held = -1;
      end else begin
         held = g;
      end
   endtask

   // Drive one cycle, compare at negedge, advance the model at the posedge.
   task automatic do_cycle(input logic [N-1:0] v, input logic rdy, input int want_rdy, input string tag);
      int          g;
      logic [N-1:0] er;
      data_t       ed;
      bus.inp_valid_i = v;
      for (int i = 0; i < N; i++) bus.inp_data_i[i] = d[i];
      bus.oup_ready_i = rdy;
      @(negedge clk);
      g  = exp_grant(v);
      er = '0;
      if (g >= 0 && rdy) er[g] = 1'b1;
      ed = (g >= 0) ? d[g] : '0;
      check($sformatf("%s valid", tag), 32'(bus.oup_valid_o), 32'(|v));
      check($sformatf("%s data", tag), bus.oup_data_o, ed);
      check($sformatf("%s ready", tag), 32'(bus.inp_ready_o), 32'(er));
      if (want_rdy >= 0) check($sformatf("%s ready_const", tag), 32'(bus.inp_ready_o), want_rdy);
      @(posedge clk);
      if (rst_n) model_advance(v, rdy);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      bus.inp_valid_i = '0;
      bus.oup_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] v;
      logic         rdy;
      int           g;
      logic         v1;
      logic         r1;
      data_t        d1;

      for (int i = 0; i < N; i++) d[i] = 32'h1000 + i;
      bus.inp_data_i   = '0;
      bus.inp_valid_i  = '0;
      bus.oup_ready_i  = 1'b0;
      bus1.inp_data_i  = '0;
      bus1.inp_valid_i = '0;
      bus1.oup_ready_i = 1'b0;

      // Single request from input 2, then ptr must sit at 3.
      do_reset();
      d[2] = 32'h0000_00A5;
      do_cycle(4'b0100, 1'b1, 4, "only2");
      do_cycle(4'b1001, 1'b1, 8, "ptr3");

      // Full load from reset: strict 0,1,2,3 rotation.
      do_reset();
      for (int k = 0; k < 8; k++) do_cycle(4'b1111, 1'b1, 1 << (k % 4), $sformatf("full%0d", k));

      // Stall on input 1 while input 0 arrives: no preemption.
      do_reset();
      d[1] = 32'h1111_1111;
      d[0] = 32'h2222_2222;
      do_cycle(4'b0010, 1'b0, 0, "hold_a");
      do_cycle(4'b0011, 1'b0, 0, "hold_b");
      do_cycle(4'b0011, 1'b0, 0, "hold_c");
      do_cycle(4'b0011, 1'b1, 2, "hand1");
      do_cycle(4'b0001, 1'b1, 1, "then0");

      // Idle: everything zero whatever oup_ready_i does.
      do_cycle(4'b0000, 1'b0, 0, "idle_r0");
      do_cycle(4'b0000, 1'b1, 0, "idle_r1");

      // Reset while input 3 is locked: afterwards input 0 wins.
      do_cycle(4'b1000, 1'b0, 0, "stall3a");
      do_cycle(4'b1001, 1'b0, 0, "stall3b");
      rst_n = 1'b0;
      model_reset();
      do_cycle(4'b1001, 1'b0, 0, "in_reset");
      rst_n = 1'b1;
      do_cycle(4'b1001, 1'b1, 1, "post_reset");

      // Random protocol-compliant traffic.
      do_reset();
      v = '0;
      for (int c = 0; c < 2000; c++) begin
         rdy = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (!v[i]) begin
               v[i] = ($urandom_range(0, 2) != 0);
               d[i] = $urandom;
            end
         end
         g = exp_grant(v);
         do_cycle(v, rdy, -1, "rand");
         if (g >= 0 && rdy) v[g] = 1'b0;
      end

      // Single-input instance: pure pass-through.
      v1 = 1'b0;
      r1 = 1'b0;
      d1 = '0;
      for (int c = 0; c < 1000; c++) begin
         if (!(v1 && !r1)) begin
            v1 = 1'($urandom_range(0, 1));
            d1 = $urandom;
         end
         r1 = 1'($urandom_range(0, 1));
         bus1.inp_valid_i  = v1;
         bus1.inp_data_i[0] = d1;
         bus1.oup_ready_i  = r1;
         @(negedge clk);
         check("n1 valid", 32'(bus1.oup_valid_o), 32'(v1));
         check("n1 data", bus1.oup_data_o, v1 ? d1 : 32'd0);
         check("n1 ready", 32'(bus1.inp_ready_o), 32'(v1 & r1));
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
